// File: rtl/exp16_arb_pkg.sv
// Shared constants and helpers for the exp16 shared-pipeline arbiter.
package exp16_arb_pkg;

  localparam int unsigned LAT_MUL   = 6;
  localparam int unsigned LAT_ADD   = 11;
  // range reduction, table lookup and result packing
  localparam int unsigned LAT_FIXED = 6;
  localparam int unsigned EXP16_LAT = 2 * LAT_MUL + 2 * LAT_ADD + LAT_FIXED;

  localparam logic [15:0] H_ZERO = 16'h0000;
  localparam logic [15:0] H_ONE  = 16'h3C00;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exp16_res_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO is kept only
// when the same cycle also pops.
module exp16_res_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= next_ptr(wr_q);
      if (pop_ok)  rd_q <= next_ptr(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg.sv
// Plain resettable delay line of DEPTH stages.
module shift_reg #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/exp16_share_arb.sv
// Round-robin, credit-gated sharing of one non-stallable FP16 exp pipeline.
// Optional EXP16_ARB_LATCHK_EN adds a sticky lat_err latency-mismatch flag.
module exp16_share_arb
  import exp16_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DW         = 16,
  parameter int unsigned EXP_LAT    = EXP16_LAT,
  parameter int unsigned FIFO_DEPTH = 48
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     exp_valid_o,
  output logic [DW-1:0]            exp_x_o,
  input  logic                     exp_valid_i,
  input  logic [DW-1:0]            exp_y_i,
  output logic                     res_valid,
  output logic [DW-1:0]            res_data,
  output logic [tag_w(N_REQ)-1:0]  res_tag,
  input  logic                     res_ready,
  output logic                     busy
`ifdef EXP16_ARB_LATCHK_EN
  ,
  output logic                     lat_err
`endif
);

  localparam int unsigned TW = tag_w(N_REQ);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic            run_q;
  logic [TW-1:0]   rr_q, rr_d, gnt_idx;
  logic [TW:0]     arb_sum;
  logic            gnt_found, credit_ok, xfer, pop;
  logic [CW-1:0]   credit_q, credit_d;
  logic            exp_valid_q, busy_q;
  logic [DW-1:0]   exp_x_q;
  logic [TW-1:0]   tag_q;
  logic [TW:0]     pipe_head;
  logic            head_v;
  logic [TW-1:0]   head_tag, push_tag;
  logic [DW+TW-1:0] fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            unused_fifo_status;

  // First valid requester at or after rr_q, cyclically; run_q keeps grants off in reset.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_sum   = '0;
    req_ready = '0;
    credit_ok = (credit_q < CW'(FIFO_DEPTH));
    for (int unsigned k = 0; k < N_REQ; k++) begin
      arb_sum = {1'b0, rr_q} + (TW+1)'(k);
      if (arb_sum >= (TW+1)'(N_REQ)) arb_sum = arb_sum - (TW+1)'(N_REQ);
      if (!gnt_found && req_valid[arb_sum[TW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = arb_sum[TW-1:0];
      end
    end
    xfer = run_q & credit_ok & gnt_found;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  assign pop = ~fifo_empty & res_ready;

  always_comb begin
    rr_d = rr_q;
    if (xfer) rr_d = (gnt_idx == TW'(N_REQ - 1)) ? '0 : gnt_idx + TW'(1);
    case ({xfer, pop})
      2'b10:   credit_d = credit_q + CW'(1);
      2'b01:   credit_d = credit_q - CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q       <= 1'b0;
      rr_q        <= '0;
      credit_q    <= '0;
      busy_q      <= 1'b0;
      exp_valid_q <= 1'b0;
      exp_x_q     <= '0;
      tag_q       <= '0;
    end else begin
      run_q       <= 1'b1;
      rr_q        <= rr_d;
      credit_q    <= credit_d;
      busy_q      <= (credit_d != '0);
      exp_valid_q <= xfer;
      if (xfer) begin
        exp_x_q <= req_data[gnt_idx*DW +: DW];
        tag_q   <= gnt_idx;
      end
    end
  end

  assign exp_valid_o = exp_valid_q;
  assign exp_x_o     = exp_x_q;
  assign busy        = busy_q;

  // Tag travels beside the exp unit; its head lines up with exp_valid_i.
  shift_reg #(.W(TW + 1), .DEPTH(EXP_LAT)) u_tag_pipe (
    .clk  (clk),
    .rstn (rstn),
    .d_i  ({exp_valid_q, tag_q}),
    .q_o  (pipe_head)
  );

  assign head_v   = pipe_head[TW];
  assign head_tag = pipe_head[TW-1:0];
  assign push_tag = head_v ? head_tag : '0;

  exp16_res_fifo #(.W(DW + TW), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (exp_valid_i),
    .wdata_i ({push_tag, exp_y_i}),
    .pop_i   (res_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign res_valid             = ~fifo_empty;
  assign {res_tag, res_data}   = fifo_rdata;
  assign unused_fifo_status    = ^{fifo_full, fifo_count};

`ifdef EXP16_ARB_LATCHK_EN
  logic lat_err_q;

  // Sticky: valid misalignment with the tag pipe, or a push into a full buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_err_q <= 1'b0;
    end else if ((exp_valid_i != head_v) || (exp_valid_i && fifo_full)) begin
      lat_err_q <= 1'b1;
    end
  end

  assign lat_err = lat_err_q;
`endif

endmodule

// File: tb/tb_exp16_share_arb.sv
// Self-checking bench for exp16_share_arb with a stub exp unit and scoreboard.
// Also exercises lat_err when built with EXP16_ARB_LATCHK_EN.
module tb_exp16_share_arb;
  import exp16_arb_pkg::*;

  localparam int unsigned N_REQ      = 4;
  localparam int unsigned DW         = 16;
  localparam int unsigned EXP_LAT    = 40;
  localparam int unsigned FIFO_DEPTH = 48;
  localparam int unsigned TW         = 2;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                exp_valid_o, exp_valid_i;
  logic [DW-1:0]       exp_x_o, exp_y_i;
  logic                res_valid, res_ready, busy;
  logic [DW-1:0]       res_data;
  logic [TW-1:0]       res_tag;
`ifdef EXP16_ARB_LATCHK_EN
  logic                lat_err;
`endif

  always #5 clk = ~clk;

  exp16_share_arb #(
    .N_REQ(N_REQ), .DW(DW), .EXP_LAT(EXP_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .exp_valid_o(exp_valid_o), .exp_x_o(exp_x_o),
    .exp_valid_i(exp_valid_i), .exp_y_i(exp_y_i),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .res_ready(res_ready), .busy(busy)
`ifdef EXP16_ARB_LATCHK_EN
    , .lat_err(lat_err)
`endif
  );

  // Small standalone FIFO for the full push+pop corner.
  logic       f_push, f_pop, f_full, f_empty;
  logic [7:0] f_wdata, f_rdata;
  logic [2:0] f_count;

  exp16_res_fifo #(.W(8), .DEPTH(4)) u_fifo (
    .clk(clk), .rstn(rstn), .push_i(f_push), .wdata_i(f_wdata), .pop_i(f_pop),
    .rdata_o(f_rdata), .full_o(f_full), .empty_o(f_empty), .count_o(f_count)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] stub_fn(input logic [DW-1:0] x);
    return (x == H_ONE) ? 16'h4170 : ((x ^ 16'hA5A5) + 16'd1);
  endfunction

  // Stub exp unit: EXP_LAT deep, or one deeper when stub_extra is set.
  logic [DW:0] stub_q [EXP_LAT+1];
  bit          stub_extra = 1'b0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= int'(EXP_LAT); i++) stub_q[i] <= '0;
    end else begin
      stub_q[0] <= {exp_valid_o, stub_fn(exp_x_o)};
      for (int i = 1; i <= int'(EXP_LAT); i++) stub_q[i] <= stub_q[i-1];
    end
  end

  assign {exp_valid_i, exp_y_i} = stub_extra ? stub_q[EXP_LAT] : stub_q[EXP_LAT-1];

  // Scoreboard: expectation pushed on accept, compared on result pop.
  typedef struct packed { logic [TW-1:0] tag; logic [DW-1:0] data; } sb_t;
  sb_t sb_q [$];
  sb_t ent, got_e;
  int  acc_cnt [N_REQ];

  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          ent.tag  = TW'(i);
          ent.data = stub_fn(req_data[i*DW +: DW]);
          sb_q.push_back(ent);
          acc_cnt[i] <= acc_cnt[i] + 1;
        end
      end
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL sb_res: got result %0h/%0h expected none", res_tag, res_data);
        end else begin
          got_e = sb_q.pop_front();
          chk("sb_res", {res_tag, res_data}, {got_e.tag, got_e.data});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int bad = 0;
    req_valid = '0;
    res_ready = 1'b1;
    for (int n = 0; n < 300 && (busy || sb_q.size() != 0); n++) begin
      if (sb_q.size() != 0 && !busy) bad++;
      step();
    end
    chk({name, "_busy_low"}, busy, 0);
    chk({name, "_busy_held"}, bad, 0);
    chk({name, "_sb_empty"}, sb_q.size(), 0);
  endtask

  typedef struct { logic [N_REQ-1:0] rv; logic [N_REQ-1:0] rdy; } vec_t;
  vec_t vecs [13];

  initial begin
    int n, base [N_REQ];
    int acc_c;
    bit got;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad, acc_c;
    int base [N_REQ];
    bit got;

    // round-robin vectors, rr pointer starting at 0
    vecs[0]  = '{4'b0000, 4'b0000};
    vecs[1]  = '{4'b1010, 4'b0010};
    vecs[2]  = '{4'b1010, 4'b1000};
    vecs[3]  = '{4'b0001, 4'b0001};
    vecs[4]  = '{4'b0001, 4'b0001};
    vecs[5]  = '{4'b1111, 4'b0010};
    vecs[6]  = '{4'b0011, 4'b0001};
    vecs[7]  = '{4'b0100, 4'b0100};
    vecs[8]  = '{4'b1111, 4'b1000};
    vecs[9]  = '{4'b1100, 4'b0100};
    vecs[10] = '{4'b0110, 4'b0010};
    vecs[11] = '{4'b0000, 4'b0000};
    vecs[12] = '{4'b1111, 4'b0100};

    for (int i = 0; i < int'(N_REQ); i++) acc_cnt[i] = 0;
    req_valid = '1;
    req_data  = '0;
    res_ready = 1'b0;
    f_push = 1'b0; f_pop = 1'b0; f_wdata = '0;

    // reset state with requests already pending
    step(); step(); mid();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_exp_valid", exp_valid_o, 0);
    chk("rst_exp_x", exp_x_o, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_busy", busy, 0);
    step();
    req_valid = '0;
    rstn = 1'b1;
    step();

    // arbitration table
    res_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      req_valid = vecs[i].rv;
      req_data  = {$urandom(), $urandom()};
      mid();
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].rdy);
      step();
    end
    drain("tbl");

    // single request latency and payload
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[2*DW +: DW] = H_ONE;
    mid();
    chk("single_ready", req_ready, 4'b0100);
    acc_c = cyc;
    step();
    req_valid = '0;
    mid();
    chk("single_exp_valid", exp_valid_o, 1);
    chk("single_exp_x", exp_x_o, 16'h3C00);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(); mid();
      if (res_valid) begin got = 1'b1; break; end
    end
    chk("single_latency", got ? 32'(cyc - acc_c) : 32'hFFFF_FFFF, EXP_LAT + 2);
    chk("single_tag", res_tag, 2);
    chk("single_data", res_data, 16'h4170);
    step();
    drain("single");

    // full contention: continuous rotation starting after requester 2
    for (int i = 0; i < int'(N_REQ); i++) base[i] = acc_cnt[i];
    req_valid = '1;
    for (int k = 0; k < 16; k++) begin
      req_data = {$urandom(), $urandom()};
      mid();
      chk($sformatf("rot%0d_ready", k), req_ready, 4'b0001 << ((3 + k) % 4));
      step();
    end
    req_valid = '0;
    for (int i = 0; i < int'(N_REQ); i++)
      chk($sformatf("rot_count%0d", i), acc_cnt[i] - base[i], 4);
    drain("rot");

    // backpressure: credits cap accepts at FIFO_DEPTH
    res_ready = 1'b0;
    req_valid = '1;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      req_data = {$urandom(), $urandom()};
      mid();
      if (|(req_valid & req_ready)) n++;
      step();
    end
    chk("bp_accepts", n, FIFO_DEPTH);
    chk("bp_ready_zero", req_ready, 0);
    chk("bp_busy", busy, 1);
    res_ready = 1'b1;
    mid();
    chk("pulse_same_cycle", req_ready, 0);
    step();
    res_ready = 1'b0;
    mid();
    chk("pulse_next_cycle", $countones(req_ready), 1);
    step();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (|(req_valid & req_ready)) n++;
      step();
    end
    chk("pulse_only_one", n, 0);
    drain("bp");

    // reset with results in flight and buffered
    res_ready = 1'b0;
    req_valid = '1;
    repeat (5) step();
    req_valid = '0;
    repeat (45) step();
    req_valid = '1;
    repeat (10) step();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_exp_valid", exp_valid_o, 0);
    chk("mid_rst_exp_x", exp_x_o, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_res_tag", res_tag, 0);
    chk("mid_rst_busy", busy, 0);
    sb_q.delete();
    step(); step();
    req_valid = '0;
    res_ready = 1'b1;
    rstn = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      mid();
      if (res_valid) bad++;
      step();
    end
    chk("post_rst_no_result", bad, 0);
    req_valid = '1;
    mid();
    chk("post_rst_rr0", req_ready, 4'b0001);
    step();
    drain("post_rst");

    // random traffic
    for (int k = 0; k < 1200; k++) begin
      req_valid = N_REQ'($urandom());
      req_data  = {$urandom(), $urandom()};
      res_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain("rand");

`ifdef EXP16_ARB_LATCHK_EN
    chk("latchk_matched", lat_err, 0);
    stub_extra = 1'b1;
    req_valid = 4'b0001;
    req_data  = {$urandom(), $urandom()};
    step();
    req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (res_valid) begin got = 1'b1; break; end
    end
    chk("latchk_result_seen", got, 1);
    chk("latchk_rise", lat_err, 1);
    repeat (10) step();
    chk("latchk_sticky", lat_err, 1);
    drain("latchk");
    stub_extra = 1'b0;
`endif

    // standalone FIFO: push+pop while full, push while full dropped
    for (int v = 1; v <= 4; v++) begin
      f_push = 1'b1; f_wdata = 8'(v);
      step();
    end
    f_push = 1'b0;
    mid();
    chk("fifo_fill_count", f_count, 4);
    chk("fifo_fill_full", f_full, 1);
    chk("fifo_fill_head", f_rdata, 1);
    step();
    f_push = 1'b1; f_wdata = 8'd5; f_pop = 1'b1;
    step();
    f_push = 1'b0; f_pop = 1'b0;
    mid();
    chk("fifo_pp_count", f_count, 4);
    chk("fifo_pp_head", f_rdata, 2);
    step();
    f_push = 1'b1; f_wdata = 8'd6;
    step();
    f_push = 1'b0;
    mid();
    chk("fifo_drop_count", f_count, 4);
    step();
    f_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("fifo_order%0d", k), f_rdata, 8'(k + 2));
      step();
    end
    f_pop = 1'b0;
    mid();
    chk("fifo_empty", f_empty, 1);
    chk("fifo_empty_data", f_rdata, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/exp16_share_arb.md
Name: exp16_share_arb

Overview:
- Shares one fixed-latency FP16 exp pipeline (II=1, valid-only, no stall input) among N_REQ requesters. Typical requesters are SSM lanes computing exp(dt*A).
- Arbitrates requests round-robin and issues one operand per cycle to the exp unit.
- Carries each request's requester tag alongside the exp pipeline and returns results in issue order with the tag attached.
- Uses credit-based admission, so results are never lost even though the exp pipeline cannot be stalled.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DW, 16, operand/result width (FP16).
- EXP_LAT, 40, exact valid_i→valid_o latency of the attached exp unit in cycles.
- FIFO_DEPTH, 48, result buffer entries. Must be power of 2 or any value ≥2; full throughput requires FIFO_DEPTH ≥ EXP_LAT+2.
- TW, $clog2(N_REQ), tag width (localparam, not overridable).

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- req_valid  in  N_REQ  per-requester request valid
- req_data  in  N_REQ*DW  packed operands; requester i occupies bits [i*DW +: DW]
- req_ready  out  N_REQ  one-hot grant/accept
- exp_valid_o  out  1  to exp unit valid_i
- exp_x_o  out  DW  to exp unit x_i
- exp_valid_i  in  1  from exp unit valid_o
- exp_y_i  in  DW  from exp unit y_o
- res_valid  out  1  result available
- res_data  out  DW  exp result
- res_tag  out  TW  originating requester index
- res_ready  in  1  result consumer accept
- busy  out  1  any credit outstanding (in flight or buffered)

Behaviour:
- Reset (already decided): reset rstn, asynchronous, active-low; clock clk.
- All outputs are 0 during reset. Reset also clears the RR pointer, credit counter, tag pipe and FIFO.
- Credits:
  - credit_cnt in [0, FIFO_DEPTH]; credit_ok = credit_cnt < FIFO_DEPTH.
  - +1 on issue, −1 on pop (res_valid & res_ready). Both in the same cycle: unchanged.
- Arbitration (combinational):
  - Among req_valid, grant the first index ≥ rr_ptr, cyclically, and only when credit_ok.
  - req_ready is one-hot or zero. req_ready[i] never depends on req_valid[j] for j≠i, except through the grant itself.
  - A transfer happens on req_valid[i] & req_ready[i].
  - On transfer, rr_ptr ← (granted index + 1) mod N_REQ, wrapping from N_REQ−1 to 0. With no transfer, rr_ptr holds.
- Issue stage (registered):
  - exp_valid_o and exp_x_o appear 1 cycle after the accept.
  - exp_valid_o is 0 in every cycle not preceded by an accept. exp_x_o holds its last value when idle.
- Tag pipe:
  - Shift register of depth EXP_LAT carrying {valid, tag}, loaded in step with exp_valid_o.
  - Its head aligns with exp_valid_i.
- Result FIFO:
  - Push {tag head, exp_y_i} on exp_valid_i.
  - First-word-fall-through: an entry is visible on res_* the cycle after its push.
  - Pop on res_valid & res_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full and popping.
- Latency: accept at cycle c → exp_valid_o at c+1 → exp_valid_i at c+1+EXP_LAT → res_valid at c+2+EXP_LAT.
- Throughput: 1 issue/cycle while credits last. With res_ready held low, exactly FIFO_DEPTH requests are accepted, then req_ready is all 0.
- Ordering: results leave in global issue order. res_tag identifies the requester.
- Boundaries:
  - FIFO overflow is unreachable by construction.
  - A push while full, which can only occur after an EXP_LAT mismatch, is dropped.
  - res_valid/res_data/res_tag are stable while res_valid=1 and res_ready=0.
  - busy = (credit_cnt != 0).
- Reset mid-operation: in-flight and buffered results are discarded. The exp unit shares rstn, so no stale exp_valid_i follows.

Optional Feature:
- Macro: EXP16_ARB_LATCHK_EN.
- Defined:
  - Adds output port lat_err (1 bit), sticky until reset.
  - lat_err is set when exp_valid_i ≠ tag-pipe head valid, or on a push while the FIFO is full.
  - A check cycle compares the two valids. On mismatch the tag-pipe entry is consumed, and the push still follows exp_valid_i.
- Undefined: no port and no comparison logic. The tag-pipe valid bit is still used for tag alignment.

Decomposition:
- Shared package exp16_arb_pkg:
  - tag width function (clog2).
  - exp unit total latency constant EXP16_LAT, derived from LAT_MUL=6 and LAT_ADD=11 plus fixed stages.
  - FP16 constants H_ZERO and H_ONE.
- Sub-module: exp16_res_fifo. Parameterised FWFT FIFO of width DW+TW with full/empty/count, holding the pointers and storage.
- Arbiter, credit counter, issue register and tag pipe stay in the top module. The tag pipe reuses the existing shift_reg.

Test Plan:
- Single requester: req 2 sends x=16'h3C00 at cycle 10 with res_ready=1 → exp_valid_o at cycle 11 with x=3C00; res_valid at 12+EXP_LAT with res_tag=2 and res_data equal to the model exp(1.0)≈16'h4170.
- All 4 requesters hold valid, res_ready=1, 16 cycles → grants cycle 0,1,2,3,0,…; each requester gets 4 accepts; no idle cycle; res_tag sequence matches the grant sequence.
- res_ready=0, all requesting → exactly FIFO_DEPTH=48 accepts, then req_ready=0. A single res_ready pulse releases exactly one new accept, in the following cycle. busy stays 1 until the FIFO drains.
- Same-cycle push+pop while full (FIFO_DEPTH=4, EXP_LAT=2 build) → count stays 4, no data loss, order preserved.
- Assert rstn low with 10 results in flight and 5 buffered → all outputs 0 in the same cycle. After release, no res_valid appears before a new request and rr_ptr=0 (requester 0 wins a full contention).
- With EXP16_ARB_LATCHK_EN defined, drive a stub exp unit with EXP_LAT+1 latency → lat_err rises on the first result and stays 1. With a matched stub, lat_err remains 0 over 1000 random requests.
